// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the matmul tile controller
package matmul_pkg;

  localparam int DIM_DEFAULT    = 4;
  localparam int AWIDTH_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } ctrl_state_t;

  // Cycles from the last operand_valid until C is stable in the PE array.
  function automatic int pipe_lat(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// rtl/matmul_addr_gen.sv - base/stride address register with modulo wrap
module matmul_addr_gen #(
  parameter int AWIDTH = 10,
  parameter int SWIDTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [AWIDTH-1:0] base,
  input  logic [SWIDTH-1:0] stride,
  output logic [AWIDTH-1:0] addr
);

  logic [AWIDTH-1:0] stride_q;

  // Stride is captured with the base so later input changes cannot disturb a running job.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= AWIDTH'(stride);
    end else if (step) begin
      addr     <= addr + stride_q;
    end
  end

endmodule

// File: rtl/matmul_tile_ctrl.sv
// rtl/matmul_tile_ctrl.sv - control and address sequencing FSM for the DIM x DIM systolic array
module matmul_tile_ctrl
  import matmul_pkg::*;
#(
  parameter int DIM      = DIM_DEFAULT,
  parameter int AWIDTH   = AWIDTH_DEFAULT,
  parameter int SWIDTH   = 8,
  parameter int KT_WIDTH = 4,
  parameter int PIPE_LAT = pipe_lat(DIM)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   accumulate,
  input  logic [KT_WIDTH-1:0]    k_tiles,
  input  logic [AWIDTH-1:0]      address_mat_a,
  input  logic [AWIDTH-1:0]      address_mat_b,
  input  logic [AWIDTH-1:0]      address_mat_c,
  input  logic [SWIDTH-1:0]      address_stride_a,
  input  logic [SWIDTH-1:0]      address_stride_b,
  input  logic [SWIDTH-1:0]      address_stride_c,
  output logic                   a_en,
  output logic                   b_en,
  output logic [AWIDTH-1:0]      a_addr,
  output logic [AWIDTH-1:0]      b_addr,
  output logic                   operand_valid,
  output logic                   pe_clear,
  output logic                   c_we,
  output logic [AWIDTH-1:0]      c_addr,
  output logic [$clog2(DIM)-1:0] c_row_sel,
  output logic                   busy,
  output logic                   done
);

  localparam int LOG_DIM = $clog2(DIM);
  localparam int FEED_W  = KT_WIDTH + LOG_DIM;
  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
  localparam int CW      = (FEED_W > DRAIN_W) ? FEED_W : DRAIN_W;

  ctrl_state_t         state, next;
  logic [CW-1:0]       cnt;
  logic [KT_WIDTH-1:0] k_eff;
  logic [CW-1:0]       feed_len;
  logic                feed_last, drain_last, write_last;
  logic                launch;
  logic                ov_q, done_q;
  logic [AWIDTH-1:0]   a_q, b_q, c_q;

  assign launch     = (state == ST_IDLE) && start;
  // DIM is a power of two, so k_eff*DIM is a shift.
  assign feed_len   = CW'({k_eff, {LOG_DIM{1'b0}}});
  assign feed_last  = (cnt == feed_len - CW'(1));
  assign drain_last = (cnt == CW'(PIPE_LAT - 1));
  assign write_last = (cnt == CW'(DIM - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      k_eff  <= '0;
      ov_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next;
      cnt    <= (next != state) ? '0 : cnt + CW'(1);
      ov_q   <= (state == ST_FEED);
      done_q <= (next == ST_DONE);
      if (launch) k_eff <= (k_tiles == '0) ? KT_WIDTH'(1) : k_tiles;
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:  if (start) next = accumulate ? ST_FEED : ST_CLEAR;
      ST_CLEAR: next = ST_FEED;
      ST_FEED:  if (feed_last) next = ST_DRAIN;
      ST_DRAIN: if (drain_last) next = ST_WRITE;
      ST_WRITE: if (write_last) next = ST_DONE;
      ST_DONE:  if (!start) next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  matmul_addr_gen #(.AWIDTH(AWIDTH), .SWIDTH(SWIDTH)) u_gen_a (
    .clk(clk), .resetn(resetn), .load(launch), .step(state == ST_FEED),
    .base(address_mat_a), .stride(address_stride_a), .addr(a_q)
  );

  matmul_addr_gen #(.AWIDTH(AWIDTH), .SWIDTH(SWIDTH)) u_gen_b (
    .clk(clk), .resetn(resetn), .load(launch), .step(state == ST_FEED),
    .base(address_mat_b), .stride(address_stride_b), .addr(b_q)
  );

  matmul_addr_gen #(.AWIDTH(AWIDTH), .SWIDTH(SWIDTH)) u_gen_c (
    .clk(clk), .resetn(resetn), .load(launch), .step(state == ST_WRITE),
    .base(address_mat_c), .stride(address_stride_c), .addr(c_q)
  );

  // Addresses are gated so the RAM buses stay quiet outside their active phases.
  assign a_en          = (state == ST_FEED);
  assign b_en          = (state == ST_FEED);
  assign a_addr        = a_en ? a_q : '0;
  assign b_addr        = b_en ? b_q : '0;
  assign operand_valid = ov_q;
  assign pe_clear      = (state == ST_CLEAR);
  assign c_we          = (state == ST_WRITE);
  assign c_addr        = c_we ? c_q : '0;
  assign c_row_sel     = c_we ? cnt[LOG_DIM-1:0] : '0;
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// tb/tb_matmul_tile_ctrl.sv - scoreboard bench for matmul_tile_ctrl
module tb_matmul_tile_ctrl;

  localparam int DIM = 4;
  localparam int AW  = 10;
  localparam int SW  = 8;
  localparam int KW  = 4;
  localparam int PL  = 3 * DIM - 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          accumulate = 1'b0;
  logic [KW-1:0] k_tiles = '0;
  logic [AW-1:0] address_mat_a = '0, address_mat_b = '0, address_mat_c = '0;
  logic [SW-1:0] address_stride_a = '0, address_stride_b = '0, address_stride_c = '0;
  logic          a_en, b_en, operand_valid, pe_clear, c_we, busy, done;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [1:0]    c_row_sel;

  matmul_tile_ctrl #(.DIM(DIM), .AWIDTH(AW), .SWIDTH(SW), .KT_WIDTH(KW), .PIPE_LAT(PL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .accumulate(accumulate), .k_tiles(k_tiles),
    .address_mat_a(address_mat_a), .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .address_stride_a(address_stride_a), .address_stride_b(address_stride_b),
    .address_stride_c(address_stride_c),
    .a_en(a_en), .b_en(b_en), .a_addr(a_addr), .b_addr(b_addr), .operand_valid(operand_valid),
    .pe_clear(pe_clear), .c_we(c_we), .c_addr(c_addr), .c_row_sel(c_row_sel),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int a;
    int b;
  } ev_t;

  ev_t q_feed[$];
  ev_t q_wr[$];
  int  q_clr[$];
  int  q_ov[$];
  int  q_done[$];
  int  vectors = 0;
  int  miscompares = 0;
  logic done_d = 1'b0;

  wire any_out = |{a_en, b_en, a_addr, b_addr, operand_valid, pe_clear, c_we, c_addr,
                   c_row_sel, busy, done};

  // Reference: event times counted from the edge E that samples start.
  task automatic push_job(input int e, input bit acc, input int kt, input int ba, input int sa,
                          input int bb, input int sb, input int bc, input int sc);
    int  clr;
    int  n;
    ev_t ev;
    clr = acc ? 0 : 1;
    n   = ((kt == 0) ? 1 : kt) * DIM;
    if (clr == 1) q_clr.push_back(e + 1);
    for (int i = 0; i < n; i++) begin
      ev.t = e + 1 + clr + i;
      ev.a = (ba + i * sa) % (1 << AW);
      ev.b = (bb + i * sb) % (1 << AW);
      q_feed.push_back(ev);
      q_ov.push_back(e + 2 + clr + i);
    end
    for (int r = 0; r < DIM; r++) begin
      ev.t = e + 1 + clr + n + PL + r;
      ev.a = (bc + r * sc) % (1 << AW);
      ev.b = r;
      q_wr.push_back(ev);
    end
    q_done.push_back(e + clr + n + PL + DIM);
  endtask

  // Monitor: values seen at this negedge are the ones sampled by edge cyc+1.
  always @(negedge clk) begin
    int  t;
    ev_t e;
    int  et;
    t = cyc + 1;
    if (resetn) begin
      if (pe_clear) begin
        vectors++;
        if (q_clr.size() == 0) begin
          miscompares++; $display("FAIL pe_clear unexpected at edge %0d", t);
        end else begin
          et = q_clr.pop_front();
          if (et != t) begin miscompares++; $display("FAIL pe_clear edge got %0d exp %0d", t, et); end
        end
      end
      if (a_en || b_en) begin
        vectors++;
        if (q_feed.size() == 0) begin
          miscompares++; $display("FAIL feed unexpected at edge %0d a=%h", t, a_addr);
        end else begin
          e = q_feed.pop_front();
          if (e.t != t || int'(a_addr) != e.a || int'(b_addr) != e.b || a_en != b_en) begin
            miscompares++;
            $display("FAIL feed got edge %0d a=%h b=%h en=%b%b exp edge %0d a=%h b=%h",
                     t, a_addr, b_addr, a_en, b_en, e.t, e.a, e.b);
          end
        end
      end
      if (operand_valid) begin
        vectors++;
        if (q_ov.size() == 0) begin
          miscompares++; $display("FAIL operand_valid unexpected at edge %0d", t);
        end else begin
          et = q_ov.pop_front();
          if (et != t) begin miscompares++; $display("FAIL operand_valid edge got %0d exp %0d", t, et); end
        end
      end
      if (c_we) begin
        vectors++;
        if (q_wr.size() == 0) begin
          miscompares++; $display("FAIL c_we unexpected at edge %0d addr=%h", t, c_addr);
        end else begin
          e = q_wr.pop_front();
          if (e.t != t || int'(c_addr) != e.a || int'(c_row_sel) != e.b) begin
            miscompares++;
            $display("FAIL c_write got edge %0d addr=%h row=%0d exp edge %0d addr=%h row=%0d",
                     t, c_addr, c_row_sel, e.t, e.a, e.b);
          end
        end
      end
      if (done && !done_d) begin
        vectors++;
        if (q_done.size() == 0) begin
          miscompares++; $display("FAIL done unexpected rise at edge %0d", cyc);
        end else begin
          et = q_done.pop_front();
          if (et != cyc) begin miscompares++; $display("FAIL done rise edge got %0d exp %0d", cyc, et); end
        end
      end
    end
    done_d <= done;
  end

  task automatic check_zero(input string name);
    vectors++;
    if (any_out) begin
      miscompares++;
      $display("FAIL %s outputs not zero: a_en=%b a=%h b=%h ov=%b clr=%b we=%b c=%h row=%0d busy=%b done=%b",
               name, a_en, a_addr, b_addr, operand_valid, pe_clear, c_we, c_addr, c_row_sel, busy, done);
    end
  endtask

  task automatic launch(input bit acc, input int kt, input int ba, input int sa, input int bb,
                        input int sb, input int bc, input int sc, input bit hold, input bit pulse);
    int e;
    @(negedge clk);
    accumulate = acc; k_tiles = KW'(kt);
    address_mat_a = AW'(ba); address_mat_b = AW'(bb); address_mat_c = AW'(bc);
    address_stride_a = SW'(sa); address_stride_b = SW'(sb); address_stride_c = SW'(sc);
    start = 1'b1;
    e = cyc + 1;
    push_job(e, acc, kt, ba, sa, bb, sb, bc, sc);
    @(negedge clk);
    if (!hold) start = 1'b0;
    address_mat_a = AW'($urandom); address_mat_b = AW'($urandom); address_mat_c = AW'($urandom);
    address_stride_a = SW'($urandom); address_stride_b = SW'($urandom);
    address_stride_c = SW'($urandom); accumulate = 1'($urandom); k_tiles = KW'($urandom);
    if (pulse && !hold) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        start = 1'($urandom);
      end
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL done timeout after %0d cycles", n); end
  endtask

  task automatic finish_job();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (done || busy || q_feed.size() != 0 || q_wr.size() != 0 || q_clr.size() != 0 ||
        q_ov.size() != 0 || q_done.size() != 0) begin
      miscompares++;
      $display("FAIL job_end done=%b busy=%b left feed=%0d wr=%0d clr=%0d ov=%0d done=%0d",
               done, busy, q_feed.size(), q_wr.size(), q_clr.size(), q_ov.size(), q_done.size());
    end
  endtask

  initial begin
    #1 check_zero("in_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1 check_zero("after_release");

    launch(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    wait_done(); finish_job();

    launch(0, 3, 'h3FC, 2, 5, 3, 'h100, 4, 0, 0);
    wait_done(); finish_job();

    launch(1, 0, 7, 1, 9, 0, 3, 0, 0, 1);
    wait_done(); finish_job();

    // Reset in the second FEED cycle abandons the job.
    launch(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b0;
    #1 check_zero("mid_reset");
    q_feed.delete(); q_wr.delete(); q_clr.delete(); q_ov.delete(); q_done.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1 check_zero("reset_release2");
    launch(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    wait_done(); finish_job();

    // start held past done: no relaunch until it drops.
    launch(0, 1, 16, 1, 32, 1, 48, 1, 1, 0);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (!done || !busy) begin
        miscompares++; $display("FAIL hold cycle %0d done=%b busy=%b exp 1 1", i, done, busy);
      end
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (done || busy) begin miscompares++; $display("FAIL hold_release done=%b busy=%b exp 0 0", done, busy); end
    finish_job();

    for (int j = 0; j < 10; j++) begin
      launch(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1023)),
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
             0, 1'($urandom));
      wait_done(); finish_job();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
